// File: rtl/atomrvcore_ifq.sv
`default_nettype none
// ============================================================================
// Module   : atomrvcore_ifq
// Purpose  : Instruction fetch queue. A DEPTH-entry FIFO of {PC, instruction}
//            pairs between the fetch and decode stages, with a branch-redirect
//            flush and an occupancy count.
// Ports    : clk_i          - clock, rising-edge active
//            PCrst_i        - asynchronous active-low reset
//            push_valid_i   - fetch presents a PC/instruction pair
//            PC_i           - PC of the pushed instruction
//            instruction_i  - pushed instruction word
//            push_ready_o   - queue has a free entry
//            flush_i        - discard every queued entry
//            pop_ready_i    - decode consumes the head entry
//            pop_valid_o    - head entry is valid
//            PC_instr_o     - PC of the head entry (0 when empty)
//            instruction_o  - instruction of the head entry (NOP when empty)
//            count_o        - number of valid entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module atomrvcore_ifq #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     PCrst_i,
  input  logic                     push_valid_i,
  input  logic [DATAWIDTH-1:0]     PC_i,
  input  logic [DATAWIDTH-1:0]     instruction_i,
  output logic                     push_ready_o,
  input  logic                     flush_i,
  input  logic                     pop_ready_i,
  output logic                     pop_valid_o,
  output logic [DATAWIDTH-1:0]     PC_instr_o,
  output logic [DATAWIDTH-1:0]     instruction_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int                   c_PTRW      = $clog2(DEPTH);
  localparam int                   c_CNTW      = c_PTRW + 1;
  localparam logic [c_CNTW-1:0]    c_DEPTH_CNT = c_CNTW'(DEPTH);
  localparam logic [DATAWIDTH-1:0] c_NOP       = DATAWIDTH'(32'h0000_0013);

  logic [DATAWIDTH-1:0] r_pc_mem    [DEPTH];
  logic [DATAWIDTH-1:0] r_instr_mem [DEPTH];
  logic [c_PTRW-1:0]    r_wr_ptr;
  logic [c_PTRW-1:0]    r_rd_ptr;
  logic [c_CNTW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  // Handshakes are qualified by registered occupancy only, so a pop in the
  // same cycle never frees a slot for a push while full.
  assign push_ready_o = (r_count < c_DEPTH_CNT);
  assign pop_valid_o  = (r_count != '0);
  assign w_push       = push_valid_i & push_ready_o & ~flush_i;
  assign w_pop        = pop_ready_i  & pop_valid_o  & ~flush_i;

  // Storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= PC_i;
      r_instr_mem[r_wr_ptr] <= instruction_i;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTRW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTRW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNTW'(1);
        2'b01:   r_count <= r_count - c_CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // No bypass: an entry is visible at the head the cycle after its push.
  assign PC_instr_o    = pop_valid_o ? r_pc_mem[r_rd_ptr]    : '0;
  assign instruction_o = pop_valid_o ? r_instr_mem[r_rd_ptr] : c_NOP;
  assign count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_atomrvcore_ifq.sv
`default_nettype none
// ============================================================================
// Module   : tb_atomrvcore_ifq
// Purpose  : Self-checking bench for atomrvcore_ifq. A queue-based reference
//            model tracks accepted entries; a monitor compares the DUT head,
//            flags and count against it every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atomrvcore_ifq;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          push_valid;
  logic [DW-1:0] pc_in;
  logic [DW-1:0] instr_in;
  logic          push_ready;
  logic          flush;
  logic          pop_ready;
  logic          pop_valid;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] instr_out;
  logic [2:0]    count;

  int            checks;
  int            errors;
  logic [63:0]   sb_q [$];
  int            exp_count;

  atomrvcore_ifq #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .PCrst_i       (rst_n),
    .push_valid_i  (push_valid),
    .PC_i          (pc_in),
    .instruction_i (instr_in),
    .push_ready_o  (push_ready),
    .flush_i       (flush),
    .pop_ready_i   (pop_ready),
    .pop_valid_o   (pop_valid),
    .PC_instr_o    (pc_out),
    .instruction_o (instr_out),
    .count_o       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_instr(input logic [DW-1:0] pc);
    return pc ^ 32'hA5A5_0093;
  endfunction

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic step(input logic pv, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                      input logic pr, input logic fl);
    push_valid = pv;
    pc_in      = pc;
    instr_in   = ins;
    pop_ready  = pr;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] pc);
    step(1'b1, pc, mk_instr(pc), 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},      64'(count),      64'd0);
    chk({tag, "_push_ready"}, 64'(push_ready), 64'd1);
    chk({tag, "_pop_valid"},  64'(pop_valid),  64'd0);
    chk({tag, "_pc"},         64'(pc_out),     64'd0);
    chk({tag, "_instr"},      64'(instr_out),  64'h13);
  endtask

  // Reference model: a plain queue updated with the acceptance rules.
  task automatic model_loop();
    bit acc_push;
    bit acc_pop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || flush) begin
        sb_q.delete();
        exp_count = 0;
      end else begin
        acc_pop  = pop_ready  && (exp_count > 0);
        acc_push = push_valid && (exp_count < DEPTH);
        if (acc_pop)  void'(sb_q.pop_front());
        if (acc_push) sb_q.push_back({pc_in, instr_in});
        exp_count = sb_q.size();
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mon_count",      64'(count),      64'(exp_count));
        chk("mon_push_ready", 64'(push_ready), 64'(exp_count < DEPTH));
        chk("mon_pop_valid",  64'(pop_valid),  64'(exp_count > 0));
        if (pop_valid) begin
          if (sb_q.size() == 0) chk("mon_head_unexpected", 64'(pop_valid), 64'd0);
          else                  chk("mon_head", {pc_out, instr_out}, sb_q[0]);
        end else begin
          chk("mon_empty_head", {pc_out, instr_out}, {32'h0, 32'h13});
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_count  = 0;
    rst_n      = 1'b0;
    push_valid = 1'b0;
    pc_in      = '0;
    instr_in   = '0;
    pop_ready  = 1'b0;
    flush      = 1'b0;

    fork
      model_loop();
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Single push, head visible next cycle.
    step(1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    chk("single_pop_valid", 64'(pop_valid), 64'd1);
    chk("single_pc",        64'(pc_out),    64'h0);
    chk("single_instr",     64'(instr_out), 64'h0050_0093);
    chk("single_count",     64'(count),     64'd1);
    drain();

    // Fill, overflow attempt, ordered drain.
    for (int i = 0; i < 4; i++) push(32'(i * 4));
    chk("full_count",      64'(count),      64'd4);
    chk("full_push_ready", 64'(push_ready), 64'd0);
    push(32'h10);
    chk("overflow_count",  64'(count),      64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", 64'(pc_out), 64'(i * 4));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", 64'(pop_valid), 64'd0);
    chk("drained_instr", 64'(instr_out), 64'h13);

    // Steady push+pop at count 2 across pointer wrap.
    push(32'h20);
    push(32'h24);
    for (int i = 0; i < 10; i++) begin
      chk("stream_count", 64'(count),  64'd2);
      chk("stream_head",  64'(pc_out), 64'(32'h20 + i * 4));
      step(1'b1, 32'(32'h28 + i * 4), mk_instr(32'(32'h28 + i * 4)), 1'b1, 1'b0);
    end
    chk("stream_end_count", 64'(count), 64'd2);
    drain();

    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 3; i++) push(32'(32'h30 + i * 4));
    step(1'b1, 32'h40, mk_instr(32'h40), 1'b1, 1'b1);
    chk("flush_count", 64'(count),      64'd0);
    chk("flush_valid", 64'(pop_valid),  64'd0);
    chk("flush_ready", 64'(push_ready), 64'd1);
    push(32'h44);
    chk("post_flush_head", 64'(pc_out), 64'h44);
    drain();

    // Reset pulse between edges.
    for (int i = 0; i < 3; i++) push(32'(32'h50 + i * 4));
    chk("pre_rst_count", 64'(count), 64'd3);
    push_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    #1 rst_n = 1'b1;
    push(32'h100);
    chk("post_rst_valid", 64'(pop_valid), 64'd1);
    chk("post_rst_head",  64'(pc_out),    64'h100);
    drain();

    // Full queue: pop frees a slot but the same-cycle push is refused.
    for (int i = 0; i < 4; i++) push(32'(32'h200 + i * 4));
    step(1'b1, 32'h210, mk_instr(32'h210), 1'b1, 1'b0);
    chk("fullpop_count", 64'(count),      64'd3);
    chk("fullpop_ready", 64'(push_ready), 64'd1);
    chk("fullpop_head",  64'(pc_out),     64'h204);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] rpc;
      rpc = $urandom;
      step(1'($urandom_range(1)), rpc, $urandom, 1'($urandom_range(1)),
           ($urandom_range(15) == 0));
    end
    drain();
    step(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
